// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: pattern load, serial data and match results.
// The bench drives through master; the detector connects through slave.
interface seq_detector_param_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  logic               load;
  logic [MAX_LEN-1:0] pat_in;
  logic [LW-1:0]      len_in;
  logic               ovl_in;
  logic               in_valid;
  logic               in;
  logic               out;
  logic               match_q;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output load, pat_in, len_in, ovl_in, in_valid, in,
    input  out, match_q, match_cnt
  );

  modport slave (
    input  load, pat_in, len_in, ovl_in, in_valid, in,
    output out, match_q, match_cnt
  );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with a Mealy match output,
// a registered match flag and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input logic                 clk,
  input logic                 reset,
  seq_detector_param_if.slave bus
);
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);
  localparam int unsigned HW      = MAX_LEN - 1;
  localparam int unsigned RST_LEN = (MAX_LEN < 3) ? MAX_LEN : 3;

  logic [MAX_LEN-1:0] pat;
  logic [LW-1:0]      len;
  logic               ovl;
  logic [HW-1:0]      hist;
  logic [LW-1:0]      fill;
  logic               match_q;
  logic [CNT_W-1:0]   match_cnt;

  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      len_last;
  logic [LW-1:0]      len_clamped;
  logic               hit;
  logic               out_c;

  // Window of the newest MAX_LEN bits, compared only over the active length.
  always_comb begin
    win      = {hist, bus.in};
    len_last = len - LW'(1);
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len);
    end
    hit   = ((win ^ pat) & mask) == '0;
    out_c = !bus.load && bus.in_valid && (fill == len_last) && hit;
  end

  always_comb begin
    len_clamped = bus.len_in;
    if (bus.len_in == '0) begin
      len_clamped = LW'(1);
    end else if (bus.len_in > LW'(MAX_LEN)) begin
      len_clamped = LW'(MAX_LEN);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat       <= MAX_LEN'(5);
      len       <= LW'(RST_LEN);
      ovl       <= 1'b1;
      hist      <= '0;
      fill      <= '0;
      match_q   <= 1'b0;
      match_cnt <= '0;
    end else if (bus.load) begin
      pat       <= bus.pat_in;
      len       <= len_clamped;
      ovl       <= bus.ovl_in;
      hist      <= '0;
      fill      <= '0;
      match_q   <= 1'b0;
      match_cnt <= '0;
    end else begin
      match_q <= out_c;
      if (bus.in_valid) begin
        hist <= win[HW-1:0];
        // Non-overlap mode restarts the history count after each match.
        if (out_c && !ovl) begin
          fill <= '0;
        end else if (fill != len_last) begin
          fill <= fill + LW'(1);
        end
      end
      if (out_c && (match_cnt != '1)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out       = out_c;
  assign bus.match_q   = match_q;
  assign bus.match_cnt = match_cnt;
endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed bench for seq_detector_param against a queue-based
// model of the accepted bit stream.
module tb_seq_detector_param;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int errors;

  // Model: accepted bits since the last clear point, oldest first.
  bit               hq[$];
  logic [MAX_LEN-1:0] m_pat;
  int               m_len;
  logic             m_ovl;
  int               m_cnt;
  logic             m_q;

  logic             exp_out;
  logic             obs_out;
  logic             obs_q;
  logic [CNT_W-1:0] obs_cnt;

  function automatic void model_reset();
    m_pat = MAX_LEN'(5);
    m_len = 3;
    m_ovl = 1'b1;
    hq.delete();
    m_cnt = 0;
    m_q   = 1'b0;
  endfunction

  // True when the newest m_len bits (including b) spell the pattern.
  function automatic logic model_out(logic ld, logic v, logic b);
    int n;
    if (ld || !v) return 1'b0;
    n = hq.size();
    if (n < m_len - 1) return 1'b0;
    if (b != m_pat[0]) return 1'b0;
    for (int k = 1; k < m_len; k++) begin
      if (hq[n-k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_step(logic ld, logic [MAX_LEN-1:0] p, int l,
                                     logic o, logic v, logic b, logic mo);
    if (ld) begin
      m_pat = p;
      m_len = (l == 0) ? 1 : ((l > MAX_LEN) ? MAX_LEN : l);
      m_ovl = o;
      hq.delete();
      m_cnt = 0;
      m_q   = 1'b0;
    end else begin
      m_q = mo;
      if (v) begin
        hq.push_back(b);
        if (hq.size() > MAX_LEN) void'(hq.pop_front());
      end
      if (mo && !m_ovl) hq.delete();
      if (mo && m_cnt < CNT_MAX) m_cnt++;
    end
  endfunction

  // One clock of stimulus; captures observed and model values for the caller.
  task automatic drive_cycle(input logic ld, input logic [MAX_LEN-1:0] p,
                             input logic [LW-1:0] l, input logic o,
                             input logic v, input logic b);
    @(negedge clk);
    bus.load     = ld;
    bus.pat_in   = p;
    bus.len_in   = l;
    bus.ovl_in   = o;
    bus.in_valid = v;
    bus.in       = b;
    #1;
    obs_out = bus.out;
    exp_out = model_out(ld, v, b);
    @(posedge clk);
    #1;
    model_step(ld, p, int'(l), o, v, b, exp_out);
    obs_q   = bus.match_q;
    obs_cnt = bus.match_cnt;
    bus.load     = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.load     = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in       = 1'b1;
    #1;
    vectors++;
    if (bus.out !== 1'b0 || bus.match_q !== 1'b0 || bus.match_cnt !== '0) begin
      $display("FAIL reset_state: out=%b match_q=%b cnt=%0d, want 0/0/0",
               bus.out, bus.match_q, bus.match_cnt);
      errors++;
    end
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_default();
    logic s [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic want [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, s[i]);
      vectors++;
      if (obs_out !== want[i] || obs_out !== exp_out || obs_q !== m_q) begin
        $display("FAIL default_101 bit%0d: out=%b q=%b, want out=%b q=%b",
                 i + 1, obs_out, obs_q, want[i], m_q);
        errors++;
      end
    end
    vectors++;
    if (obs_cnt !== CNT_W'(2)) begin
      $display("FAIL default_cnt: got %0d want 2", obs_cnt);
      errors++;
    end
  endtask

  task automatic test_overlap_mode();
    logic s [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int want_cnt [2] = '{1, 2};
    for (int m = 0; m < 2; m++) begin
      drive_cycle(1'b1, MAX_LEN'(4'b1010), LW'(4), m[0], 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, s[i]);
        vectors++;
        if (obs_out !== exp_out || obs_q !== m_q) begin
          $display("FAIL overlap ovl=%0d bit%0d: out=%b q=%b, want %b/%b",
                   m, i + 1, obs_out, obs_q, exp_out, m_q);
          errors++;
        end
      end
      vectors++;
      if (obs_cnt !== CNT_W'(want_cnt[m])) begin
        $display("FAIL overlap_cnt ovl=%0d: got %0d want %0d", m, obs_cnt, want_cnt[m]);
        errors++;
      end
    end
  endtask

  task automatic test_gaps();
    logic v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic b [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    drive_cycle(1'b1, MAX_LEN'(3'b101), LW'(3), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, v[i], b[i]);
      vectors++;
      if (obs_out !== (i == 5) || obs_out !== exp_out) begin
        $display("FAIL gaps step%0d: out=%b want %b", i, obs_out, (i == 5));
        errors++;
      end
    end
  endtask

  task automatic test_full_width();
    logic [7:0] p;
    p = 8'hA5;
    drive_cycle(1'b1, p, LW'(8), 1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, p[i]);
      vectors++;
      if (obs_out !== (i == 0) || obs_out !== exp_out) begin
        $display("FAIL full_width bit%0d: out=%b want %b", 8 - i, obs_out, (i == 0));
        errors++;
      end
    end
  endtask

  task automatic test_clamp();
    int ones;
    logic b;
    ones = 0;
    drive_cycle(1'b1, MAX_LEN'(8'hF1), LW'(0), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      b = 1'($urandom);
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, b);
      if (b) ones++;
      vectors++;
      if (obs_out !== b) begin
        $display("FAIL clamp_len0 step%0d: out=%b want %b", i, obs_out, b);
        errors++;
      end
    end
    vectors++;
    if (obs_cnt !== CNT_W'(ones)) begin
      $display("FAIL clamp_len0_cnt: got %0d want %0d", obs_cnt, ones);
      errors++;
    end
    // Oversized length behaves as MAX_LEN: eight ones match, seven do not.
    drive_cycle(1'b1, MAX_LEN'(8'hFF), LW'(15), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      vectors++;
      if (obs_out !== (i == 7) || obs_out !== exp_out) begin
        $display("FAIL clamp_len15 bit%0d: out=%b want %b", i + 1, obs_out, (i == 7));
        errors++;
      end
    end
  endtask

  task automatic test_saturation();
    drive_cycle(1'b1, MAX_LEN'(1), LW'(1), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      vectors++;
      if (obs_cnt !== CNT_W'((i + 1 > CNT_MAX) ? CNT_MAX : i + 1)) begin
        $display("FAIL saturation match%0d: cnt=%0d want %0d", i + 1, obs_cnt,
                 (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
        errors++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic s [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, s[i]);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in       = 1'b1;
    #1;
    vectors++;
    if (bus.out !== 1'b1) begin
      $display("FAIL pre_reset_match: out=%b want 1", bus.out);
      errors++;
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (bus.out !== 1'b0 || bus.match_cnt !== '0) begin
      $display("FAIL async_reset: out=%b cnt=%0d want 0/0", bus.out, bus.match_cnt);
      errors++;
    end
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (obs_out !== 1'b0 || obs_cnt !== '0) begin
      $display("FAIL post_reset_1: out=%b cnt=%0d want 0/0", obs_out, obs_cnt);
      errors++;
    end
  endtask

  task automatic test_load_collision();
    logic s [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, s[i]);
    drive_cycle(1'b1, MAX_LEN'(5), LW'(3), 1'b1, 1'b1, 1'b1);
    vectors++;
    if (obs_out !== 1'b0 || obs_cnt !== '0 || obs_q !== 1'b0) begin
      $display("FAIL load_collision: out=%b cnt=%0d q=%b want 0/0/0",
               obs_out, obs_cnt, obs_q);
      errors++;
    end
  endtask

  task automatic test_random();
    logic             ld;
    logic [MAX_LEN-1:0] p;
    logic [LW-1:0]    l;
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 24) == 0);
      p  = MAX_LEN'($urandom);
      l  = ($urandom_range(0, 1) != 0) ? LW'($urandom_range(1, 3))
                                       : LW'($urandom_range(0, 15));
      drive_cycle(ld, p, l, 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
      vectors++;
      if (obs_out !== exp_out || obs_q !== m_q || obs_cnt !== CNT_W'(m_cnt)) begin
        $display("FAIL random cyc%0d: out=%b q=%b cnt=%0d want %b/%b/%0d",
                 i, obs_out, obs_q, obs_cnt, exp_out, m_q, m_cnt);
        errors++;
      end
    end
  endtask

  initial begin
    vectors      = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.load     = 1'b0;
    bus.pat_in   = '0;
    bus.len_in   = '0;
    bus.ovl_in   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in       = 1'b0;
    model_reset();
    test_reset();
    test_default();
    test_overlap_mode();
    test_gaps();
    test_full_width();
    test_clamp();
    test_saturation();
    test_reset_midstream();
    test_load_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised, runtime-programmable serial pattern detector. It is the next generation of the fixed 3-bit "101" recogniser. Pattern, length and overlap mode are loaded at run time, and input is qualified by a valid strobe. It keeps a combinational Mealy match output plus a registered match flag and a saturating match counter. It sits on the serial input path of the lab datapath, ahead of the event and statistics logic.

## Interface
Parameters:
- MAX_LEN, default 8: maximum pattern length in bits, at least 2.
- CNT_W, default 8: width of the match counter.
- LW, derived as $clog2(MAX_LEN+1): width of the length field. Not user-overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; returns every register to its reset value immediately.
- load  in  1  when high, latches pat_in, len_in and ovl_in, and clears the history.
- pat_in  in  MAX_LEN  pattern; bit len-1 is the first bit received, bit 0 the last.
- len_in  in  LW  pattern length; 0 clamps to 1, values above MAX_LEN clamp to MAX_LEN.
- ovl_in  in  1  overlap mode: 1 = overlapping matches allowed, 0 = non-overlapping.
- in_valid  in  1  qualifies `in` for this cycle.
- in  in  1  serial data bit.
- out  out  1  Mealy match, combinational; high in the cycle the completing bit is presented.
- match_q  out  1  `out` registered; high for one cycle, the cycle after a match.
- match_cnt  out  CNT_W  matches since reset or the last load; saturates at all-ones.

## Operation
Internal state:
- pat, MAX_LEN bits.
- len, LW bits.
- ovl, 1 bit.
- hist, MAX_LEN-1 bits: the most recent accepted bits, newest in bit 0.
- fill, LW bits: the number of valid history bits, range 0..len-1.

Reset values:
- pat = 'b101 (zero-extended), len = 3, ovl = 1.
- hist = 0, fill = 0.
- match_q = 0, match_cnt = 0.
- With these values the block detects overlapping "101" immediately after reset.

Match condition:
- out = !load && in_valid && (fill == len-1) && ({hist, in} low len bits == pat low len bits).
- When len = 1, only the `in` bit is compared.

Accepted bit (in_valid=1, load=0):
- hist shifts left with `in` entering bit 0.
- If out=1 and ovl=0, fill goes to 0.
- Otherwise fill goes to min(fill+1, len-1).

No valid bit (in_valid=0): hist, fill and the counter all hold; out=0.

Load (load=1):
- pat, len and ovl take their new values; len is clamped as described for len_in.
- hist, fill, match_cnt and match_q are all cleared.
- The `in` bit presented in that cycle is discarded, and out=0.

Counter:
- match_cnt increments on every cycle where out=1.
- It holds at 2^CNT_W-1 and does not wrap.

Unused bits of pat above len are ignored in the compare.

## Timing
- out has 0-cycle latency: it is combinational from in, in_valid and load in the same cycle as the last pattern bit.
- match_q and match_cnt update on the edge that ends the match cycle.
- Back-to-back valid bits are accepted every cycle; there is no backpressure.
- Gaps (in_valid=0) do not break a partial match; history is preserved across them.
- Asserting reset mid-stream clears everything asynchronously, and out drops in the same cycle.
- The first match after deassert requires len valid bits.
- When load and a completing bit coincide, load wins: no match and no count.

## Test plan
- Post-reset default: after reset, stream 1,0,1,0,1 with valid every cycle. Required: out high on bits 3 and 5; match_q high the following cycles; match_cnt = 2.
- Non-overlap: load pat=0b1010, len=4, ovl=0, then stream 1,0,1,0,1,0. Required: exactly one match, on bit 4; match_cnt = 1. With ovl=1 the same stream gives matches on bits 4 and 6, match_cnt = 2.
- Valid gaps: with len=3, pat=101, present 1, gap, gap, 0, gap, 1. Required: out high on the final valid bit only.
- Full-width and clamp:
  - MAX_LEN=8, load len=8, pat=0xA5, stream 0xA5 MSB first. Required: match on bit 8.
  - Load len_in=0 with pat bit0=1. Required: every valid 1 matches.
- Saturation: with CNT_W=4, drive 20 matches. Required: match_cnt holds at 15.
- Reset and load mid-operation:
  - Async reset after "10". Required: fill cleared, the next "1" does not match, out low.
  - Load asserted in the same cycle as a completing bit. Required: out=0, counter 0.
